mem_port_arbiter: RTL

Two-requester arbiter that shares one Avalon-MM-style memory port (the memA/memB interface that feeds `ram_1rw_byte_mask_out_reg_wrap`) between two engine-side masters. Commands are muxed with zero added latency under round-robin arbitration, and write bursts hold the grant until their last beat. Read data is routed back to the issuing requester through an outstanding-read tag FIFO. It sits between the engine's memory clients and the memory wrapper.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto one Avalon-MM-style memory port, with write-burst lock and read-return tag FIFO.
// Define MEM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module mem_port_arbiter #(
  parameter int MEM_ADDR_W      = 27,
  parameter int MEM_DATA_W      = 512,
  parameter int MEM_BURST_CNT_W = 7,
  parameter int MEM_WR_MASK_W   = MEM_DATA_W / 8,
  parameter int RD_TAG_LOG_ELS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_read,
  input  logic                       req0_write,
  input  logic [MEM_ADDR_W-1:0]      req0_address,
  input  logic [MEM_BURST_CNT_W-1:0] req0_burstcount,
  input  logic [MEM_DATA_W-1:0]      req0_writedata,
  input  logic [MEM_WR_MASK_W-1:0]   req0_byteenable,
  output logic                       req0_ready,
  output logic [MEM_DATA_W-1:0]      req0_readdata,
  output logic                       req0_readdatavalid,
  input  logic                       req1_read,
  input  logic                       req1_write,
  input  logic [MEM_ADDR_W-1:0]      req1_address,
  input  logic [MEM_BURST_CNT_W-1:0] req1_burstcount,
  input  logic [MEM_DATA_W-1:0]      req1_writedata,
  input  logic [MEM_WR_MASK_W-1:0]   req1_byteenable,
  output logic                       req1_ready,
  output logic [MEM_DATA_W-1:0]      req1_readdata,
  output logic                       req1_readdatavalid,
  input  logic                       mem_ready_in,
  output logic                       mem_read_out,
  output logic                       mem_write_out,
  output logic [MEM_ADDR_W-1:0]      mem_address_out,
  output logic [MEM_BURST_CNT_W-1:0] mem_burstcount_out,
  output logic [MEM_DATA_W-1:0]      mem_writedata_out,
  output logic [MEM_WR_MASK_W-1:0]   mem_byteenable_out,
  input  logic [MEM_DATA_W-1:0]      mem_readdata_in,
  input  logic                       mem_readdatavalid_in,
  output logic                       err_unexp_rdata
);

  localparam int RD_TAG_ELS = 1 << RD_TAG_LOG_ELS;
  localparam logic [MEM_BURST_CNT_W-1:0] BC_ONE = MEM_BURST_CNT_W'(1);

  typedef enum logic {ARB, WR_BURST} state_t;
  typedef struct packed {
    logic                       id;
    logic [MEM_BURST_CNT_W-1:0] bc;
  } tag_t;

  state_t                     state, state_nxt;
  logic [MEM_BURST_CNT_W-1:0] beats_left, beats_left_nxt;
  logic                       lock_id, lock_id_nxt;
  logic                       last_gnt, last_gnt_nxt;
  logic                       gnt_any, gnt_id;

  tag_t                       tag_mem [RD_TAG_ELS];
  logic [RD_TAG_LOG_ELS-1:0]  wr_ptr, rd_ptr;
  logic [RD_TAG_LOG_ELS:0]    tag_cnt;
  logic [MEM_BURST_CNT_W-1:0] head_cnt;
  logic                       tag_full, tag_empty;
  tag_t                       head;

  logic                       sel_read, sel_write, cmd_ok, ready_any;
  logic                       push, pop, wr_beat, accept, rdv_ok;
  logic [MEM_BURST_CNT_W-1:0] sel_bc, sel_bc_eff;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == WR_BURST) begin
      gnt_any = 1'b1;
      gnt_id  = lock_id;
    end else if ((req0_read | req0_write) && (req1_read | req1_write)) begin
      gnt_any = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      gnt_id  = 1'b0;
`else
      gnt_id  = ~last_gnt;
`endif
    end else if (req0_read | req0_write) begin
      gnt_any = 1'b1;
    end else if (req1_read | req1_write) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  assign sel_read           = gnt_id ? req1_read       : req0_read;
  assign sel_write          = gnt_id ? req1_write      : req0_write;
  assign sel_bc             = gnt_id ? req1_burstcount : req0_burstcount;
  assign sel_bc_eff         = (sel_bc == '0) ? BC_ONE : sel_bc;
  assign mem_address_out    = gnt_id ? req1_address    : req0_address;
  assign mem_burstcount_out = sel_bc;
  assign mem_writedata_out  = gnt_id ? req1_writedata  : req0_writedata;
  assign mem_byteenable_out = gnt_id ? req1_byteenable : req0_byteenable;

  // A granted read is withheld entirely while the tag FIFO is full, even if a pop lands this cycle.
  assign cmd_ok        = gnt_any & ~rst & ~(sel_read & tag_full);
  assign mem_read_out  = cmd_ok & sel_read;
  assign mem_write_out = cmd_ok & sel_write;
  assign ready_any     = cmd_ok & mem_ready_in;
  assign req0_ready    = ready_any & ~gnt_id;
  assign req1_ready    = ready_any &  gnt_id;

  assign push    = ready_any & sel_read;
  assign wr_beat = ready_any & sel_write;
  assign accept  = push | wr_beat;

  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    lock_id_nxt    = lock_id;
    last_gnt_nxt   = accept ? gnt_id : last_gnt;
    case (state)
      ARB: begin
        if (wr_beat && sel_bc_eff > BC_ONE) begin
          state_nxt      = WR_BURST;
          beats_left_nxt = sel_bc_eff - BC_ONE;
          lock_id_nxt    = gnt_id;
        end
      end
      WR_BURST: begin
        if (wr_beat) begin
          beats_left_nxt = beats_left - BC_ONE;
          if (beats_left == BC_ONE) state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      beats_left <= '0;
      lock_id    <= 1'b0;
      last_gnt   <= 1'b1;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      lock_id    <= lock_id_nxt;
      last_gnt   <= last_gnt_nxt;
    end
  end

  assign tag_full  = (tag_cnt == (RD_TAG_LOG_ELS + 1)'(RD_TAG_ELS));
  assign tag_empty = (tag_cnt == '0);
  assign head      = tag_mem[rd_ptr];

  assign rdv_ok             = mem_readdatavalid_in & ~tag_empty & ~rst;
  assign pop                = rdv_ok & (head_cnt == head.bc - BC_ONE);
  assign req0_readdatavalid = rdv_ok & ~head.id;
  assign req1_readdatavalid = rdv_ok &  head.id;
  assign req0_readdata      = mem_readdata_in;
  assign req1_readdata      = mem_readdata_in;

  // NOTE: tag storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= '{id: gnt_id, bc: sel_bc_eff};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_cnt         <= '0;
      head_cnt        <= '0;
      err_unexp_rdata <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + RD_TAG_LOG_ELS'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + RD_TAG_LOG_ELS'(1);
        head_cnt <= '0;
      end else if (rdv_ok) begin
        head_cnt <= head_cnt + BC_ONE;
      end
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + (RD_TAG_LOG_ELS + 1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (RD_TAG_LOG_ELS + 1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (mem_readdatavalid_in && tag_empty) err_unexp_rdata <= 1'b1;
    end
  end

endmodule
